// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern transmitter and detector benches.
package pattern_pkg;

  localparam int unsigned PAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Reference patterns shared with the detector test harnesses.
  localparam logic [PAT_W-1:0] PAT_A5C3 = 16'hA5C3;
  localparam logic [PAT_W-1:0] PAT_8001 = 16'h8001;
  localparam logic [PAT_W-1:0] PAT_FFFF = 16'hFFFF;
  localparam logic [PAT_W-1:0] PAT_C0DE = 16'hC0DE;
  localparam logic [PAT_W-1:0] PAT_1234 = 16'h1234;

endpackage

// File: rtl/pattern_shreg.sv
// Rotate-left pattern register; rotation keeps the captured pattern intact for repeats.
module pattern_shreg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb,
  output logic             msb_next
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], q[WIDTH-1]};
    end
  end

  // msb_next is the bit that becomes MSB after one rotation.
  assign msb      = q[WIDTH-1];
  assign msb_next = q[WIDTH-2];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: MSB-first frames with sof/valid markers, repeats and idle gaps.
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int unsigned WIDTH = PAT_W,
  parameter int unsigned GAP   = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] rep,
  output logic             sdata,
  output logic             svalid,
  output logic             sof,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_t           state, state_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             sdata_n, svalid_n, sof_n, busy_n, done_n;
  logic             load, shift, msb, msb_next;

  pattern_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .din      (pattern),
    .msb      (msb),
    .msb_next (msb_next)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
      sdata     <= 1'b0;
      svalid    <= 1'b0;
      sof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      frame_cnt <= frame_cnt_n;
      gap_cnt   <= gap_cnt_n;
      sdata     <= sdata_n;
      svalid    <= svalid_n;
      sof       <= sof_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Output values are computed for the cycle following the edge, so all outputs stay registered.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    frame_cnt_n = frame_cnt;
    gap_cnt_n   = gap_cnt;
    load        = 1'b0;
    shift       = 1'b0;
    sdata_n     = 1'b0;
    svalid_n    = 1'b0;
    sof_n       = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          load        = 1'b1;
          frame_cnt_n = rep;
          bit_cnt_n   = '0;
          gap_cnt_n   = '0;
          state_n     = ST_SHIFT;
          sdata_n     = pattern[WIDTH-1];
          svalid_n    = 1'b1;
          sof_n       = 1'b1;
          busy_n      = 1'b1;
        end
      end

      ST_SHIFT: begin
        shift = 1'b1;
        if (bit_cnt == BIT_W'(WIDTH - 1)) begin
          bit_cnt_n = '0;
          if (frame_cnt == '0) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            frame_cnt_n = frame_cnt - CNT_W'(1);
            busy_n      = 1'b1;
            if (GAP > 0) begin
              state_n   = ST_GAP;
              gap_cnt_n = '0;
            end else begin
              sdata_n  = msb_next;
              svalid_n = 1'b1;
              sof_n    = 1'b1;
            end
          end
        end else begin
          bit_cnt_n = bit_cnt + BIT_W'(1);
          sdata_n   = msb_next;
          svalid_n  = 1'b1;
          busy_n    = 1'b1;
        end
      end

      ST_GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == GAP_W'(GAP - 1)) begin
          state_n   = ST_SHIFT;
          bit_cnt_n = '0;
          sdata_n   = msb;
          svalid_n  = 1'b1;
          sof_n     = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx with a loopback deserializer/detector model.
module tb_pattern_tx;
  import pattern_pkg::*;

  localparam int unsigned W      = 16;
  localparam int unsigned TB_GAP = 2;
  localparam int unsigned CW     = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic [W-1:0]  pattern = '0;
  logic [CW-1:0] rep     = '0;
  logic          sdata, svalid, sof, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  pattern_tx #(.WIDTH(W), .GAP(TB_GAP), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pattern (pattern),
    .rep     (rep),
    .sdata   (sdata),
    .svalid  (svalid),
    .sof     (sof),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Loopback: deserialize valid bits and flag a complete frame equal to PAT_A5C3.
  logic [W-1:0] det_sr  = '0;
  int           det_cnt = 0;
  logic         z       = 1'b0;

  always_ff @(posedge clk) begin
    if (svalid) begin
      det_sr  <= {det_sr[W-2:0], sdata};
      det_cnt <= sof ? 1 : det_cnt + 1;
    end
    z <= svalid && !sof && (det_cnt == W - 1) && ({det_sr[W-2:0], sdata} == PAT_A5C3);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, sdata, svalid, sof, busy, done};
  endfunction

  // Checks a whole run cycle by cycle; ends sampling the done cycle.
  task automatic expect_run(input logic [W-1:0] pat, input int r, input int inj,
                            input int exp_busy, input string tag);
    int nbusy = 0;
    for (int f = 0; f <= r; f++) begin
      for (int b = 0; b < W; b++) begin
        chk(tag, outs(), {27'd0, pat[W-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
        nbusy += int'(busy);
        if (f == 0 && b == inj) begin
          start   = 1'b1;
          pattern = 16'h0000;
          rep     = '1;
        end
        step();
        if (f == 0 && b == inj) start = 1'b0;
      end
      if (f < r) begin
        for (int g = 0; g < int'(TB_GAP); g++) begin
          chk({tag, "_gap"}, outs(), 32'b00010);
          nbusy += int'(busy);
          step();
        end
      end
    end
    chk({tag, "_done"}, outs(), 32'b00001);
    chk({tag, "_busy_cycles"}, nbusy, exp_busy);
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("reset", outs(), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", outs(), 32'd0);

    // 1: single frame A5C3
    pattern = PAT_A5C3; rep = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    expect_run(PAT_A5C3, 0, -1, 16, "t1");
    step();
    chk("t1_idle", outs(), 32'd0);

    // 2: three frames of 8001 with gaps
    pattern = PAT_8001; rep = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    expect_run(PAT_8001, 2, -1, 52, "t2");
    step();
    chk("t2_single_done", outs(), 32'd0);

    // 3: second start at bit 5 is ignored
    pattern = PAT_FFFF; rep = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    expect_run(PAT_FFFF, 0, 5, 16, "t3");
    step();
    chk("t3_no_followon", outs(), 32'd0);
    step();
    chk("t3_no_followon2", outs(), 32'd0);

    // 4: async reset at bit 9 of a rep=1 transfer
    pattern = PAT_A5C3; rep = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 9; b++) begin
      chk("t4_pre", outs(), {27'd0, PAT_A5C3[W-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
      step();
    end
    chk("t4_bit9", outs(), {27'd0, PAT_A5C3[W-10], 1'b1, 1'b0, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1 chk("t4_async_clear", outs(), 32'd0);
    step();
    chk("t4_in_reset", outs(), 32'd0);
    step();
    chk("t4_in_reset_nodone", outs(), 32'd0);
    rst_n = 1'b1;
    step();
    chk("t4_released", outs(), 32'd0);
    pattern = PAT_1234; rep = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    expect_run(PAT_1234, 0, -1, 16, "t4_after");
    step();
    chk("t4_idle", outs(), 32'd0);

    // 5: start held high, back-to-back frames
    pattern = PAT_C0DE; rep = 4'd0; start = 1'b1;
    step();
    expect_run(PAT_C0DE, 0, -1, 16, "t5_a");
    step();
    expect_run(PAT_C0DE, 0, -1, 16, "t5_b");
    start = 1'b0;
    step();
    chk("t5_idle", outs(), 32'd0);

    // 6: loopback detector sees the match one cycle after the 16th bit
    pattern = PAT_A5C3; rep = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    expect_run(PAT_A5C3, 0, -1, 16, "t6");
    chk("t6_z_match", 32'(z), 32'd1);
    step();
    chk("t6_z_clear", 32'(z), 32'd0);
    pattern = 16'hA5C2; rep = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    expect_run(16'hA5C2, 0, -1, 16, "t6_flip");
    chk("t6_z_nomatch", 32'(z), 32'd0);
    step();

    // 7: maximum repeat count, no counter wrap
    pattern = PAT_1234; rep = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    expect_run(PAT_1234, 15, -1, 286, "t7");
    step();
    chk("t7_idle", outs(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
Serial transmitter for 16-bit match patterns. It captures a parallel pattern on a start request and shifts it out MSB-first, one bit per clock, with valid and start-of-frame markers. It can repeat the frame a programmable number of times, with fixed idle gaps between frames. It is the driving end for the pattern detectors: test harnesses and loopback paths use it to feed words into a deserializer/detector chain.

Parameters:
WIDTH, 16, pattern/frame length in bits (≥2)
GAP, 2, idle cycles between repeated frames (≥0)
CNT_W, 4, width of repeat-count input

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to transmit; sampled only in IDLE
pattern  input  WIDTH  parallel pattern, captured in the start cycle
rep  input  CNT_W  extra repeats, captured with pattern; total frames = rep+1
sdata  output  1  serial data, MSB first
svalid  output  1  high on every cycle sdata carries a frame bit
sof  output  1  high with svalid on bit WIDTH-1 of each frame
busy  output  1  high from the cycle after accepted start until return to IDLE
done  output  1  one-cycle pulse when the last bit of the last frame has been sent

Behaviour:
- Reset (async, rst_n=0): state=IDLE; sdata, svalid, sof, busy, done = 0; shift reg, bit and frame counters cleared. Reset mid-frame aborts immediately, with no done pulse. The first accepted start after reset release is normal.
- All outputs are registered.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 captures pattern into shift reg and rep into frame counter, clears bit counter, goes to SHIFT.
  - The first bit appears on sdata the cycle after start (latency 1).
- SHIFT:
  - sdata = shreg[WIDTH-1], svalid=1; sof=1 when bit counter=0.
  - Each cycle shreg rotates left by 1, so the original pattern is retained for repeats; bit counter increments.
  - After bit WIDTH-1:
    - frame counter=0 → IDLE, done=1 in the following cycle (same cycle busy drops).
    - else → decrement frame counter; GAP if GAP>0, otherwise straight back to SHIFT (frames back-to-back).
- GAP: svalid=0, sdata=0, busy=1, for exactly GAP cycles, then SHIFT with bit counter=0.
- start while busy: ignored, not queued; pattern/rep changes while busy have no effect.
- Back-to-back runs: start asserted in the done cycle is accepted (FSM is already IDLE). The next frame's first bit follows with no extra idle.
- sdata and sof are 0 whenever svalid=0.
- Cycle counts:
  - frame = WIDTH cycles
  - total busy cycles = (rep+1)*WIDTH + rep*GAP
  - rep at maximum (2^CNT_W−1) must work without counter wrap.

Decomposition:
- Shared package pattern_pkg:
  - state typedef (IDLE/SHIFT/GAP)
  - PAT_W=16 default width constant
  - common test patterns (e.g. PAT_A5C3=16'hA5C3), reused by the detector benches.
- One natural sub-module: pattern_shreg.
  - WIDTH-bit rotate-left register with load and shift enables, MSB output, async active-low clear.
  - The FSM and counters stay in pattern_tx.

Test Plan:
1. pattern=16'hA5C3, rep=0, start one cycle → sdata = 1010_0101_1100_0011 over 16 cycles, svalid high 16 cycles, sof only on first, done pulse on cycle 17 after start, busy high 16 cycles.
2. pattern=16'h8001, rep=2, GAP=2 → three identical frames, sof three times, svalid low exactly 2 cycles between frames, busy high 52 cycles, single done.
3. Start at t0 with 16'hFFFF, second start with 16'h0000 at bit 5 → second start ignored, all 16 bits =1, one done only, no follow-on frame.
4. rst_n low at bit 9 of a rep=1 transfer → all outputs 0 asynchronously, no done. After release, start with 16'h1234 transmits cleanly from its MSB.
5. start held high continuously with 16'hC0DE, rep=0 → back-to-back frames separated only by the done/IDLE cycle, each frame correct.
6. Loopback: pattern_tx output deserialized into a 16-bit register feeding the detector, pattern=matching constant → detector z=1 exactly one cycle after the 16th bit, z=0 for a one-bit-flipped pattern.
